red_pitaya_rst_seq: RTL and testbench
=====================================

RED_PITAYA_RST_SEQ -- requirements
Module: red_pitaya_rst_seq

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1024: consecutive synchronized-locked cycles required before any reset release; legal range 2..65535.
REQ-002 SHALL have parameter DAC_DLY, default 16: cycles between rst_adc and rst_dac release; legal range 1..255.
REQ-003 SHALL have parameter CNT_W, default 8: width of the loss-of-lock counter.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is in this domain.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port pll_locked, input, 1: PLL LOCKED status, asynchronous to clk.
REQ-007 SHALL have port clr, input, 1: synchronous clear of lol_sticky and lol_cnt.
REQ-008 SHALL have port rst_adc, output, 1: active-high reset for the ADC domain.
REQ-009 SHALL have port rst_dac, output, 1: active-high reset for the DAC domains.
REQ-010 SHALL have port locked_ok, output, 1: sequence complete, clocks stable.
REQ-011 SHALL have port lol_sticky, output, 1: a loss of lock occurred after release.
REQ-012 SHALL have port lol_cnt, output, CNT_W: saturating count of loss-of-lock events.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchronizer to produce locked_s, which is the only form consumed by the FSM.
REQ-014 SHALL implement FSM states WAIT_LOCK, SETTLE, REL_ADC, RUN and LOST, with outputs registered together with the state.
REQ-015 SHALL transition WAIT_LOCK->SETTLE on locked_s=1, clearing the settle counter.
REQ-016 SHALL transition SETTLE->WAIT_LOCK on locked_s=0, with no loss event counted; SHALL transition SETTLE->REL_ADC after SETTLE_CYC consecutive cycles in SETTLE.
REQ-017 SHALL deassert rst_adc on entry to REL_ADC, then after DAC_DLY cycles enter RUN, deasserting rst_dac and asserting locked_ok on the same edge.
REQ-018 Timing, with t0 as the edge where the first sync flop captures pll_locked=1: rst_adc SHALL fall at t0+SETTLE_CYC+2 and rst_dac at t0+SETTLE_CYC+DAC_DLY+2.
REQ-019 On locked_s=0 in REL_ADC or RUN, SHALL enter LOST on the next edge, asserting both resets and clearing locked_ok; latency is at most 3 clk edges from the pll_locked fall.
REQ-020 LOST SHALL last exactly one cycle, then go to WAIT_LOCK.
REQ-021 SHALL count one loss event per LOST entry: set lol_sticky, increment lol_cnt, saturating at 2^CNT_W-1 with no wrap.
REQ-022 clr SHALL zero lol_sticky and lol_cnt; if clr coincides with a loss event, the result SHALL be lol_cnt=1 and lol_sticky=1.
REQ-023 rst_adc=0 SHALL imply state REL_ADC or RUN; rst_dac=0 SHALL imply RUN; rst_dac SHALL never be low while rst_adc is high.

Reset
REQ-024 While rst=1, SHALL force state=WAIT_LOCK, sync flops=0, counters=0, rst_adc=1, rst_dac=1, locked_ok=0, lol_sticky=0, lol_cnt=0, asynchronously.
REQ-025 rst asserted mid-sequence, including RUN, SHALL NOT count as a loss event; after release the sequence restarts from WAIT_LOCK.

Configuration
REQ-026 Macro RED_PITAYA_RST_SEQ_LOL_CNT_EN defined: lol_cnt SHALL behave per REQ-021/022.
REQ-027 Macro undefined: lol_cnt SHALL be constant 0 with no counter flops; lol_sticky, the FSM and all timing SHALL be unchanged.

Structure
REQ-028 SHALL place the FSM state enum typedef in package red_pitaya_rst_seq_pkg.
REQ-029 SHALL implement the synchronizer as sub-module red_pitaya_sync, parameterized by stage count, with its flops reset by rst to 0.

Verification (SETTLE_CYC=16, DAC_DLY=4, CNT_W=2, macro defined unless stated)
REQ-030 SHALL cover: rst released, pll_locked held 1 -> rst_adc falls 18 edges after t0, rst_dac and locked_ok at 22, lol_cnt=0.
REQ-031 SHALL cover: pll_locked low for 3 cycles at cycle 8 of SETTLE -> no release, lol_cnt=0, lol_sticky=0; release occurs 18 edges after the new t0.
REQ-032 SHALL cover: in RUN, pll_locked falls -> both resets high within 3 edges, lol_cnt=1, lol_sticky=1; relock re-releases at +18/+22.
REQ-033 SHALL cover: 5 loss events -> lol_cnt saturates at 3; clr coincident with a 6th loss -> lol_cnt=1, lol_sticky=1.
REQ-034 SHALL cover: rst pulsed in RUN -> resets high immediately (async), lol_cnt=0, no loss counted.
REQ-035 SHALL cover: macro undefined, repeat REQ-032 -> lol_cnt stays 0, lol_sticky=1.

Source files
------------

// File: rtl/red_pitaya_rst_seq_pkg.sv
// ============================================================================
// Module      : red_pitaya_rst_seq_pkg
// Description : Shared types and constants for the PLL-lock reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package red_pitaya_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_REL_ADC   = 3'd2,
        ST_RUN       = 3'd3,
        ST_LOST      = 3'd4
    } rst_seq_state_t;

    // Wide enough for the largest legal settle (65535) and DAC delay (255).
    localparam int TMR_W       = 16;
    localparam int SYNC_STAGES = 2;

    function automatic logic adc_released(input rst_seq_state_t s);
        return (s == ST_REL_ADC) || (s == ST_RUN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/red_pitaya_sync.sv
// ============================================================================
// Module      : red_pitaya_sync
// Description : Multi-stage flop synchronizer, cleared to 0 by rst.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module red_pitaya_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    generate
        if (STAGES == 1) begin : g_single
            assign sync_d = d;
        end else begin : g_chain
            assign sync_d = {sync_q[STAGES-2:0], d};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/red_pitaya_rst_seq.sv
// ============================================================================
// Module      : red_pitaya_rst_seq
// Description : Sequences ADC/DAC reset release after PLL lock, tracks loss
//               of lock. Define RED_PITAYA_RST_SEQ_LOL_CNT_EN for lol_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module red_pitaya_rst_seq
    import red_pitaya_rst_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 1024,
    parameter int DAC_DLY    = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             clr,
    output logic             rst_adc,
    output logic             rst_dac,
    output logic             locked_ok,
    output logic             lol_sticky,
    output logic [CNT_W-1:0] lol_cnt
);

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] DAC_LAST    = TMR_W'(DAC_DLY - 1);

    logic           locked_s;
    rst_seq_state_t state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic           rst_adc_q, rst_adc_d;
    logic           rst_dac_q, rst_dac_d;
    logic           locked_ok_q, locked_ok_d;
    logic           lol_sticky_q, lol_sticky_d;
    logic           loss_evt;

    red_pitaya_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Outputs are derived from the next state so they register with it.
    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (locked_s) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!locked_s)                state_d = ST_WAIT_LOCK;
                else if (tmr_q == SETTLE_LAST) state_d = ST_REL_ADC;
                else                           tmr_d   = tmr_q + TMR_W'(1);
            end
            ST_REL_ADC: begin
                if (!locked_s)              state_d = ST_LOST;
                else if (tmr_q == DAC_LAST) state_d = ST_RUN;
                else                        tmr_d   = tmr_q + TMR_W'(1);
            end
            ST_RUN: begin
                if (!locked_s) state_d = ST_LOST;
            end
            ST_LOST: begin
                state_d = ST_WAIT_LOCK;
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase

        rst_adc_d   = !adc_released(state_d);
        rst_dac_d   = (state_d != ST_RUN);
        locked_ok_d = (state_d == ST_RUN);
        loss_evt    = (state_d == ST_LOST);
    end

    // A loss on the same edge as clr wins, leaving the flag set.
    always_comb begin
        lol_sticky_d = clr ? 1'b0 : lol_sticky_q;
        if (loss_evt) lol_sticky_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_WAIT_LOCK;
            tmr_q        <= '0;
            rst_adc_q    <= 1'b1;
            rst_dac_q    <= 1'b1;
            locked_ok_q  <= 1'b0;
            lol_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            rst_adc_q    <= rst_adc_d;
            rst_dac_q    <= rst_dac_d;
            locked_ok_q  <= locked_ok_d;
            lol_sticky_q <= lol_sticky_d;
        end
    end

`ifdef RED_PITAYA_RST_SEQ_LOL_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] lol_cnt_q, lol_cnt_d;

    always_comb begin
        lol_cnt_d = clr ? '0 : lol_cnt_q;
        if (loss_evt && (lol_cnt_d != CNT_MAX)) lol_cnt_d = lol_cnt_d + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lol_cnt_q <= '0;
        end else begin
            lol_cnt_q <= lol_cnt_d;
        end
    end

    assign lol_cnt = lol_cnt_q;
`else
    assign lol_cnt = '0;
`endif

    assign rst_adc    = rst_adc_q;
    assign rst_dac    = rst_dac_q;
    assign locked_ok  = locked_ok_q;
    assign lol_sticky = lol_sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_red_pitaya_rst_seq.sv
// ============================================================================
// Module      : tb_red_pitaya_rst_seq
// Description : Self-checking bench for red_pitaya_rst_seq (small parameters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_red_pitaya_rst_seq;

    localparam int SETTLE_CYC = 16;
    localparam int DAC_DLY    = 4;
    localparam int CNT_W      = 2;
    localparam int ADC_LAT    = SETTLE_CYC + 2;
    localparam int DAC_LAT    = SETTLE_CYC + DAC_DLY + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             pll_locked;
    logic             clr;
    logic             rst_adc;
    logic             rst_dac;
    logic             locked_ok;
    logic             lol_sticky;
    logic [CNT_W-1:0] lol_cnt;

    red_pitaya_rst_seq #(
        .SETTLE_CYC (SETTLE_CYC),
        .DAC_DLY    (DAC_DLY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .clr        (clr),
        .rst_adc    (rst_adc),
        .rst_dac    (rst_dac),
        .locked_ok  (locked_ok),
        .lol_sticky (lol_sticky),
        .lol_cnt    (lol_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string name;
        int    cyc;
    } exp_t;
    exp_t sb[$];

    int   exp_cnt    = 0;
    logic exp_sticky = 1'b0;

    function automatic int cnt_after_loss(input int c, input bit clr_hit);
`ifdef RED_PITAYA_RST_SEQ_LOL_CNT_EN
        if (clr_hit) return 1;
        return (c == 3) ? 3 : c + 1;
`else
        return 0;
`endif
    endfunction

    task automatic push_exp(input string name, input int at);
        exp_t e;
        e.name = name;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Returns the posedge count after which the selected reset first shows lvl.
    task automatic wait_lvl(input int sel, input logic lvl, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (((sel == 0) ? rst_adc : rst_dac) === lvl) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b0; clr = 1'b0;
        #2;
        n_cmp++; if (rst_adc !== 1'b1)    begin n_bad++; $display("FAIL reset rst_adc: got %b need 1", rst_adc); end
        n_cmp++; if (rst_dac !== 1'b1)    begin n_bad++; $display("FAIL reset rst_dac: got %b need 1", rst_dac); end
        n_cmp++; if (locked_ok !== 1'b0)  begin n_bad++; $display("FAIL reset locked_ok: got %b need 0", locked_ok); end
        n_cmp++; if (lol_sticky !== 1'b0) begin n_bad++; $display("FAIL reset lol_sticky: got %b need 0", lol_sticky); end
        n_cmp++; if (lol_cnt !== 2'd0)    begin n_bad++; $display("FAIL reset lol_cnt: got %0d need 0", lol_cnt); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (rst_adc !== 1'b1) begin n_bad++; $display("FAIL unlocked rst_adc: got %b need 1", rst_adc); end
    endtask

    // Drives lock (or rst release with lock held) and checks release timing.
    task automatic test_relock(input bit via_rst, input string tag);
        exp_t e;
        int   at;
        int   t0;
        @(negedge clk);
        if (via_rst) rst = 1'b0;
        else         pll_locked = 1'b1;
        t0 = cyc + 1;
        push_exp({tag, " adc_release"}, t0 + ADC_LAT);
        push_exp({tag, " dac_release"}, t0 + DAC_LAT);

        e = sb.pop_front();
        wait_lvl(0, 1'b0, 40, at);
        n_cmp++;
        if (at !== e.cyc) begin n_bad++; $display("FAIL %s: got cycle %0d need %0d", e.name, at, e.cyc); end
        n_cmp++;
        if (rst_dac !== 1'b1) begin n_bad++; $display("FAIL %s dac_held: got %b need 1", tag, rst_dac); end

        e = sb.pop_front();
        wait_lvl(1, 1'b0, 40, at);
        n_cmp++;
        if (at !== e.cyc) begin n_bad++; $display("FAIL %s: got cycle %0d need %0d", e.name, at, e.cyc); end
        n_cmp++;
        if (locked_ok !== 1'b1 || rst_adc !== 1'b0) begin
            n_bad++; $display("FAIL %s run_outputs: got ok=%b adc=%b need ok=1 adc=0", tag, locked_ok, rst_adc);
        end
    endtask

    task automatic test_settle_glitch();
        int t0;
        @(negedge clk);
        pll_locked = 1'b1;
        t0 = cyc + 1;
        while (cyc < t0 + 9) @(negedge clk);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (rst_adc !== 1'b1)    begin n_bad++; $display("FAIL glitch rst_adc: got %b need 1", rst_adc); end
        n_cmp++; if (lol_cnt !== 2'd0)    begin n_bad++; $display("FAIL glitch lol_cnt: got %0d need 0", lol_cnt); end
        n_cmp++; if (lol_sticky !== 1'b0) begin n_bad++; $display("FAIL glitch lol_sticky: got %b need 0", lol_sticky); end
        test_relock(1'b0, "glitch");
        n_cmp++; if (lol_sticky !== 1'b0) begin n_bad++; $display("FAIL glitch post lol_sticky: got %b need 0", lol_sticky); end
    endtask

    task automatic test_loss(input bit clr_hit, input string tag);
        exp_t e;
        int   f;
        int   at;
        logic dac_at;
        logic ok_at;
        @(negedge clk);
        pll_locked = 1'b0;
        f = cyc + 1;
        push_exp({tag, " resets_high"}, f + 2);
        at = -1; dac_at = 1'bx; ok_at = 1'bx;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clr = clr_hit && (cyc == f + 1);
            if (at < 0 && rst_adc === 1'b1) begin
                at = cyc; dac_at = rst_dac; ok_at = locked_ok;
            end
        end
        clr = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (at !== e.cyc) begin n_bad++; $display("FAIL %s: got cycle %0d need %0d", e.name, at, e.cyc); end
        n_cmp++;
        if (dac_at !== 1'b1 || ok_at !== 1'b0) begin
            n_bad++; $display("FAIL %s lost_outputs: got dac=%b ok=%b need dac=1 ok=0", tag, dac_at, ok_at);
        end
        exp_cnt    = cnt_after_loss(exp_cnt, clr_hit);
        exp_sticky = 1'b1;
        n_cmp++; if (lol_cnt !== CNT_W'(exp_cnt)) begin n_bad++; $display("FAIL %s lol_cnt: got %0d need %0d", tag, lol_cnt, exp_cnt); end
        n_cmp++; if (lol_sticky !== exp_sticky)   begin n_bad++; $display("FAIL %s lol_sticky: got %b need %b", tag, lol_sticky, exp_sticky); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) begin
            test_loss(1'b0, $sformatf("loss%0d", i + 2));
            test_relock(1'b0, $sformatf("relock%0d", i + 2));
        end
`ifdef RED_PITAYA_RST_SEQ_LOL_CNT_EN
        n_cmp++; if (lol_cnt !== 2'd3) begin n_bad++; $display("FAIL saturate lol_cnt: got %0d need 3", lol_cnt); end
`else
        n_cmp++; if (lol_cnt !== 2'd0) begin n_bad++; $display("FAIL saturate lol_cnt: got %0d need 0", lol_cnt); end
`endif
        test_loss(1'b1, "loss6_clr");
        test_relock(1'b0, "relock6");
    endtask

    task automatic test_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        exp_cnt = 0; exp_sticky = 1'b0;
        n_cmp++; if (lol_cnt !== CNT_W'(exp_cnt)) begin n_bad++; $display("FAIL clr lol_cnt: got %0d need 0", lol_cnt); end
        n_cmp++; if (lol_sticky !== exp_sticky)   begin n_bad++; $display("FAIL clr lol_sticky: got %b need 0", lol_sticky); end
        n_cmp++; if (locked_ok !== 1'b1)          begin n_bad++; $display("FAIL clr locked_ok: got %b need 1", locked_ok); end
    endtask

    task automatic test_rst_in_run();
        test_loss(1'b0, "pre_rst_loss");
        test_relock(1'b0, "pre_rst_relock");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        exp_cnt = 0; exp_sticky = 1'b0;
        n_cmp++; if (rst_adc !== 1'b1)   begin n_bad++; $display("FAIL async rst_adc: got %b need 1", rst_adc); end
        n_cmp++; if (rst_dac !== 1'b1)   begin n_bad++; $display("FAIL async rst_dac: got %b need 1", rst_dac); end
        n_cmp++; if (locked_ok !== 1'b0) begin n_bad++; $display("FAIL async locked_ok: got %b need 0", locked_ok); end
        n_cmp++; if (lol_sticky !== 1'b0) begin n_bad++; $display("FAIL async lol_sticky: got %b need 0", lol_sticky); end
        repeat (2) @(negedge clk);
        test_relock(1'b1, "after_rst");
        n_cmp++; if (lol_cnt !== 2'd0)    begin n_bad++; $display("FAIL after_rst lol_cnt: got %0d need 0", lol_cnt); end
        n_cmp++; if (lol_sticky !== 1'b0) begin n_bad++; $display("FAIL after_rst lol_sticky: got %b need 0", lol_sticky); end
    endtask

    initial begin
        test_reset();
        test_settle_glitch();
        test_loss(1'b0, "loss1");
        test_relock(1'b0, "relock1");
        test_saturate();
        test_clr();
        test_rst_in_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
